// File: rtl/cordic_atan2_instr.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_atan2_instr
//  Purpose  : Vectoring-mode CORDIC custom instruction computing atan2(y, x).
//             FP32 operands are converted to signed Q2.15. A quadrant
//             pre-rotation is applied, then the vector is driven onto the +x
//             axis while the applied micro-rotation angles are accumulated.
//             The accumulated angle is returned as an FP32 value in radians.
//             Latency is a fixed ITER+1 enabled edges from the start edge.
//  Ports    :
//    clk                 in   clock
//    reset               in   synchronous, active-high reset
//    clk_en              in   global enable, all registers hold when low
//    start               in   begin operation (sampled only in IDLE)
//    dataa[31:0]         in   y operand, FP32
//    datab[31:0]         in   x operand, FP32
//    done                out  one-enabled-cycle pulse, result valid
//    result[31:0]        out  FP32 angle in radians, held until next done
//    input_invalid_flag  out  set at start if either operand is invalid
//    busy                out  high from accepted start until done
//  Revision : 1.0  initial release
// ============================================================================
module cordic_atan2_instr #(
    parameter int ITER  = 16,
    parameter int W     = 18,
    parameter int FRAC  = 15,
    parameter int GUARD = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic        done,
    output logic [31:0] result,
    output logic        input_invalid_flag,
    output logic        busy
);

    localparam int XYW = W + GUARD;
    localparam int CW  = $clog2(ITER + 1);

    localparam logic signed [W-1:0] HALF_PI = W'(51472);
    localparam logic [31:0]         QNAN    = 32'h7FC0_0000;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ITERATE = 2'd1,
        S_PACK    = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // FP32 -> signed fixed point. Mantissa is truncated; values too small
    // for the fractional grid flush to zero. Out-of-range values produce 0
    // here and are caught separately by the invalid check.
    // ------------------------------------------------------------------------
    function automatic logic signed [W-1:0] fp_to_fix(input logic [31:0] f);
        logic [23:0] mant;
        logic [23:0] mag;
        int          e;
        int          sh;
        e    = int'(f[30:23]);
        mant = {1'b1, f[22:0]};
        sh   = 150 - FRAC - e;
        if (e < 127 - FRAC || e > 127 || sh < 0 || sh > 23) begin
            mag = '0;
        end else begin
            mag = mant >> sh;
        end
        fp_to_fix = f[31] ? -W'(mag) : W'(mag);
    endfunction

    // exp >= 128 covers |v| >= 2.0 as well as Inf/NaN (exp = 255).
    function automatic logic fp_invalid(input logic [31:0] f);
        fp_invalid = f[30];
    endfunction

    // round(atan(2^-i) * 2^15)
    function automatic logic signed [W-1:0] atan_rom(input logic [CW-1:0] idx);
        case (int'(idx))
            0:       atan_rom = W'(25736);
            1:       atan_rom = W'(15193);
            2:       atan_rom = W'(8027);
            3:       atan_rom = W'(4075);
            4:       atan_rom = W'(2045);
            5:       atan_rom = W'(1024);
            6:       atan_rom = W'(512);
            7:       atan_rom = W'(256);
            8:       atan_rom = W'(128);
            9:       atan_rom = W'(64);
            10:      atan_rom = W'(32);
            11:      atan_rom = W'(16);
            12:      atan_rom = W'(8);
            13:      atan_rom = W'(4);
            14:      atan_rom = W'(2);
            15:      atan_rom = W'(1);
            default: atan_rom = '0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                   state_q;
    logic [CW-1:0]            i_q;
    logic signed [XYW-1:0]    x_q;
    logic signed [XYW-1:0]    y_q;
    logic signed [W-1:0]      z_q;
    logic                     zero_q;
    logic                     done_q;
    logic [31:0]              result_q;
    logic                     flag_q;
    logic                     busy_q;

    // ------------------------------------------------------------------------
    // Next-state datapath
    // ------------------------------------------------------------------------
    logic signed [W-1:0]      ya_fix;
    logic signed [W-1:0]      xb_fix;
    logic signed [XYW-1:0]    ya_ext;
    logic signed [XYW-1:0]    xb_ext;
    logic signed [XYW-1:0]    x_start_d;
    logic signed [XYW-1:0]    y_start_d;
    logic signed [W-1:0]      z_start_d;
    logic                     zero_d;
    logic                     flag_d;
    logic signed [XYW-1:0]    x_iter_d;
    logic signed [XYW-1:0]    y_iter_d;
    logic signed [W-1:0]      z_iter_d;
    logic signed [W-1:0]      ang;
    logic [W-1:0]             zmag;
    int                       lead;
    int                       expo;
    logic [22:0]              mant_d;
    logic [31:0]              result_d;

    always_comb begin
        // Operand capture and quadrant pre-rotation
        ya_fix = fp_to_fix(dataa);
        xb_fix = fp_to_fix(datab);
        ya_ext = XYW'(ya_fix);
        xb_ext = XYW'(xb_fix);
        flag_d = fp_invalid(dataa) | fp_invalid(datab);
        // Both operands zero after conversion (includes -0 and flushed
        // tiny values): the angle is forced to +0 at pack time.
        zero_d = (ya_fix == '0) && (xb_fix == '0);

        if (xb_fix[W-1] && !ya_fix[W-1]) begin
            x_start_d = ya_ext;
            y_start_d = -xb_ext;
            z_start_d = HALF_PI;
        end else if (xb_fix[W-1] && ya_fix[W-1]) begin
            x_start_d = -ya_ext;
            y_start_d = xb_ext;
            z_start_d = -HALF_PI;
        end else begin
            x_start_d = xb_ext;
            y_start_d = ya_ext;
            z_start_d = '0;
        end

        // One micro-rotation, direction chosen to drive y toward zero
        ang = atan_rom(i_q);
        if (!y_q[XYW-1]) begin
            x_iter_d = x_q + (y_q >>> i_q);
            y_iter_d = y_q - (x_q >>> i_q);
            z_iter_d = z_q + ang;
        end else begin
            x_iter_d = x_q - (y_q >>> i_q);
            y_iter_d = y_q + (x_q >>> i_q);
            z_iter_d = z_q - ang;
        end

        // Angle -> FP32: leading-one position sets the exponent, the bits
        // below it become the left-aligned mantissa.
        zmag = z_q[W-1] ? W'(-z_q) : W'(z_q);
        lead = 0;
        for (int k = 0; k < W; k++) begin
            if (zmag[k]) begin
                lead = k;
            end
        end
        expo   = 127 + lead - FRAC;
        mant_d = 23'({23'b0, zmag} << (23 - lead));

        if (flag_q) begin
            result_d = QNAN;
        end else if (zero_q || (zmag == '0)) begin
            result_d = 32'h0000_0000;
        end else begin
            result_d = {z_q[W-1], 8'(expo), mant_d};
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'h0000_0000;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else if (clk_en) begin
            // done is a single enabled-cycle pulse
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        x_q     <= x_start_d;
                        y_q     <= y_start_d;
                        z_q     <= z_start_d;
                        zero_q  <= zero_d;
                        flag_q  <= flag_d;
                        i_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_ITERATE;
                    end
                end
                S_ITERATE: begin
                    x_q <= x_iter_d;
                    y_q <= y_iter_d;
                    z_q <= z_iter_d;
                    i_q <= i_q + 1'b1;
                    if (i_q == CW'(ITER - 1)) begin
                        state_q <= S_PACK;
                    end
                end
                S_PACK: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign done               = done_q;
    assign result             = result_q;
    assign input_invalid_flag = flag_q;
    assign busy               = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_cordic_atan2_instr.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cordic_atan2_instr
//  Purpose  : Directed self-checking bench for cordic_atan2_instr. Expected
//             angles are hand-computed FP32 constants compared with a
//             raw-word tolerance equal to 2^-13 rad at the value's exponent.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cordic_atan2_instr;

    localparam logic [31:0] ONE     = 32'h3F80_0000;
    localparam logic [31:0] MONE    = 32'hBF80_0000;
    localparam logic [31:0] MHALF   = 32'hBF00_0000;
    localparam logic [31:0] TWO     = 32'h4000_0000;
    localparam logic [31:0] NAN_IN  = 32'h7FC0_0000;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] PI_4    = 32'h3F49_0FDB;
    localparam logic [31:0] M_PI_4  = 32'hBF49_0FDB;
    localparam logic [31:0] PI      = 32'h4049_0FDB;
    localparam logic [31:0] M_2P678 = 32'hC02B_6374;
    // 2^-13 rad in ULPs: exponent -1 -> 2^11, exponent +1 -> 2^9
    localparam int TOL_E_M1 = 2048;
    localparam int TOL_E_P1 = 512;

    logic        clk;
    logic        reset;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        done;
    logic [31:0] result;
    logic        input_invalid_flag;
    logic        busy;

    int total;
    int bad;

    cordic_atan2_instr #(
        .ITER  (16),
        .W     (18),
        .FRAC  (15),
        .GUARD (3)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .clk_en             (clk_en),
        .start              (start),
        .dataa              (dataa),
        .datab              (datab),
        .done               (done),
        .result             (result),
        .input_invalid_flag (input_invalid_flag),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Compare obs against exp; tol is the permitted distance in raw FP32
    // words of the same sign (0 means exact).
    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp, input int tol);
        int  diff;
        bit  ok;
        total++;
        if (obs[31] != exp[31]) begin
            ok = 1'b0;
        end else begin
            diff = int'({1'b0, obs[30:0]}) - int'({1'b0, exp[30:0]});
            if (diff < 0) diff = -diff;
            ok = (diff <= tol);
        end
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives start for exactly one edge (E0).
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Ticks until done, counting clock edges after E0 starting from n0.
    // busy_gap reports busy dropping before done.
    task automatic wait_done(input int n0, output int n, output bit busy_gap);
        n = n0;
        busy_gap = 1'b0;
        while (!done && n < 80) begin
            if (!busy) busy_gap = 1'b1;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int tol, input logic flag_exp);
        int n;
        bit gap;
        issue(a, b);
        wait_done(0, n, gap);
        check({tag, " latency"}, 32'(n), 32'd17, 0);
        check({tag, " busy gap"}, {31'b0, gap}, 32'd0, 0);
        check({tag, " result"}, result, exp, tol);
        check({tag, " flag"}, {31'b0, input_invalid_flag}, {31'b0, flag_exp}, 0);
        check({tag, " busy at done"}, {31'b0, busy}, 32'd0, 0);
    endtask

    initial begin
        int  n;
        int  pulses;
        bit  gap;
        logic [31:0] held;

        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        datab  = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("rst done",   {31'b0, done},               32'd0, 0);
        check("rst busy",   {31'b0, busy},               32'd0, 0);
        check("rst result", result,                      32'd0, 0);
        check("rst flag",   {31'b0, input_invalid_flag}, 32'd0, 0);

        // pi/4 with explicit busy-after-E0 and done-drop checks
        issue(ONE, ONE);
        check("pi4 busy E0", {31'b0, busy}, 32'd1, 0);
        wait_done(0, n, gap);
        check("pi4 latency", 32'(n), 32'd17, 0);
        check("pi4 busy gap", {31'b0, gap}, 32'd0, 0);
        check("pi4 result", result, PI_4, TOL_E_M1);
        check("pi4 flag", {31'b0, input_invalid_flag}, 32'd0, 0);
        tick();
        check("pi4 done drop", {31'b0, done}, 32'd0, 0);

        run_op("pi",     32'h0000_0000, MONE, PI,      TOL_E_P1, 1'b0);
        run_op("mpi4",   MONE,          ONE,  M_PI_4,  TOL_E_M1, 1'b0);
        run_op("m2p678", MHALF,         MONE, M_2P678, TOL_E_P1, 1'b0);
        run_op("zero",   32'h0000_0000, 32'h0000_0000, 32'h0, 0, 1'b0);
        run_op("negzero", 32'h8000_0000, 32'h8000_0000, 32'h0, 0, 1'b0);
        run_op("nan y",  NAN_IN, ONE, QNAN, 0, 1'b1);
        run_op("x two",  ONE,    TWO, QNAN, 0, 1'b1);
        run_op("valid after inv", ONE, ONE, PI_4, TOL_E_M1, 1'b0);

        // start while busy is ignored; start in the done cycle is accepted
        issue(ONE, ONE);
        repeat (4) tick();
        dataa = 32'h0000_0000;
        datab = MONE;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(5, n, gap);
        check("ign latency", 32'(n), 32'd17, 0);
        check("ign result", result, PI_4, TOL_E_M1);
        issue(32'h0000_0000, MONE);
        check("reissue done drop", {31'b0, done}, 32'd0, 0);
        check("reissue busy", {31'b0, busy}, 32'd1, 0);
        wait_done(0, n, gap);
        check("reissue latency", 32'(n), 32'd17, 0);
        check("reissue result", result, PI, TOL_E_P1);

        // clk_en stall mid-iteration, then hold while done is high
        issue(MONE, ONE);
        repeat (2) tick();
        clk_en = 1'b0;
        repeat (5) tick();
        clk_en = 1'b1;
        wait_done(7, n, gap);
        check("stall latency", 32'(n), 32'd22, 0);
        check("stall result", result, M_PI_4, TOL_E_M1);
        held   = result;
        clk_en = 1'b0;
        repeat (3) tick();
        check("stall done held", {31'b0, done}, 32'd1, 0);
        check("stall result held", result, held, 0);
        clk_en = 1'b1;
        tick();
        check("stall done drop", {31'b0, done}, 32'd0, 0);

        // reset mid-operation aborts with no done pulse
        issue(NAN_IN, 32'h0000_0000);
        check("abort flag set", {31'b0, input_invalid_flag}, 32'd1, 0);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort done",   {31'b0, done},               32'd0, 0);
        check("abort busy",   {31'b0, busy},               32'd0, 0);
        check("abort result", result,                      32'd0, 0);
        check("abort flag",   {31'b0, input_invalid_flag}, 32'd0, 0);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (done) pulses++;
        end
        check("abort no done", 32'(pulses), 32'd0, 0);
        run_op("after abort", ONE, ONE, PI_4, TOL_E_M1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cordic_atan2_instr.md
Name: cordic_atan2_instr

Overview:
Vectoring-mode CORDIC custom-instruction unit that computes atan2(y, x). It is the inverse of the rotation-mode cos/sin instruction and uses the same start/done instruction handshake. Operands y (dataa) and x (datab) arrive as IEEE-754 single-precision floats and are converted to fixed point. The unit iterates the vector onto the +x axis, accumulates the angle, and returns it as an FP32 result in radians.

Parameters:
ITER, 16, number of CORDIC micro-rotations (1..17)
W, 18, signed fixed-point width of operands and angle
FRAC, 15, fractional bits; operands Q2.15, angle Q2.15 (covers ±pi)
GUARD, 3, extra MSBs on internal x/y datapath for CORDIC gain and pre-rotation growth

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
clk_en  in  1  global enable; all registers hold when low
start  in  1  begin operation; sampled only in IDLE with clk_en high
dataa  in  32  y operand, FP32
datab  in  32  x operand, FP32
done  out  1  one-enabled-cycle pulse, result valid
result  out  32  FP32 angle in radians, range [-pi, pi]; held until next done
input_invalid_flag  out  1  registered at start; 1 if either operand invalid
busy  out  1  high from accepted start until done pulse

Behaviour:
- Reset values: done=0, result=0x00000000, input_invalid_flag=0, busy=0, state=IDLE, iteration counter=0. Reset mid-operation aborts immediately with no done pulse.
- All state changes require clk_en=1. With clk_en=0 every register, including done, holds its value.
- States: IDLE -> ITERATE -> PACK -> IDLE. Edge numbering below counts enabled edges only.
- IDLE, start=1, edge E0:
  - Convert both operands FP->fixed Q2.15. Truncate the mantissa. Flush exp < 112 to 0.
  - Operand is invalid if exp=255 (Inf/NaN) or |v| >= 2.0 (exp >= 128). Register input_invalid_flag.
  - Pre-rotate:
    - x<0 and y>=0: x'=y, y'=-x, z=+pi/2.
    - x<0 and y<0: x'=-y, y'=x, z=-pi/2.
    - Otherwise x'=x, y'=y, z=0.
  - Set busy=1, i=0, state=ITERATE.
- ITERATE, edges E1..E_ITER, one micro-rotation per edge:
  - y>=0: x+=y>>>i, y-=x>>>i, z+=atan_tab[i].
  - y<0: x-=y>>>i, y+=x>>>i, z-=atan_tab[i].
  - Shifts are arithmetic. x/y are W+GUARD bits wide; z is W bits.
  - atan_tab[i] = round(atan(2^-i)·2^FRAC), constant ROM. pi/2 = 51472, pi = 102944.
  - The last iteration moves to PACK.
- PACK, edge E_ITER+1:
  - Convert z to FP32. Sign from z, magnitude = |z|.
  - A leading-one priority encoder gives p; exponent = 127 + p − FRAC; mantissa = bits below the leading one, left-aligned, zero-filled.
  - z=0 gives 0x00000000.
  - If input_invalid_flag=1, result=0x7FC00000 instead.
  - done=1, busy=0, state=IDLE.
- done drops on the next enabled edge. Total latency from start edge to done = ITER+1 enabled edges, fixed for every input, including invalid ones and atan2(0,0).
- atan2(±0, ±0) returns 0x00000000 with the flag clear. Negative zero is treated as +0.
- start while busy is ignored; operands are sampled only at E0. start in the same enabled cycle done is high is accepted (state is already IDLE).
- Accuracy: |result − atan2(y,x)| ≤ 2^-13 rad for valid inputs with |x|,|y| ≥ 2^-10.

Test Plan:
- y=0x3F800000, x=0x3F800000, start -> done after 17 enabled edges; result ≈ pi/4 (0x3F490FDB ± 2^-13); flag=0; busy high E0..E16.
- y=0x00000000, x=0xBF800000 -> result ≈ pi (0x40490FDB ± tol). y=0xBF800000, x=0x3F800000 -> ≈ −pi/4 (0xBF490FDB ± tol). y=0xBF000000, x=0xBF800000 -> ≈ −2.6779 rad.
- y=0x7FC00000 (NaN) or x=0x40000000 (2.0) -> flag=1, result=0x7FC00000, done at the normal 17-edge latency. The next valid op clears the flag.
- start at E0 with y=1, x=1; second start with y=0, x=−1 at E5 -> second start ignored; single done with the pi/4 result. Re-issue the second start in the done cycle -> accepted; pi result 17 edges later.
- Toggle clk_en low for 5 cycles mid-ITERATE -> done delayed by exactly 5 clocks, value unchanged. Hold clk_en low while done=1 -> done stays 1.
- Assert reset at E8 -> done never pulses; busy=0, result=0, flag=0. A new start afterwards completes normally.
